vend_ctrl: RTL
==============

// Module: vend_ctrl
// PURPOSE
//  Parametrised coin-operated vending controller: price, coin values and stock set by parameters.
//  Accumulates credit from nickel/dime/quarter inputs and vends once credit >= PRICE.
//  Returns change one nickel per handshake with the coin dispenser; i_cancel refunds the full credit.
//  Sits between the coin acceptor front-end and the product/coin dispenser actuators.
// PARAMETERS
//  PRICE     4   product price in nickel units (4 = 20c); legal range 1..60
//  NICKEL_U  1   nickel value in units
//  DIME_U    2   dime value in units
//  QUARTER_U 5   quarter value in units
//  STOCK_MAX 15  restock value of the inventory counter (STOCK_EN only)
//  CREDIT_W  $clog2(PRICE+QUARTER_U+1)  credit register width (derived, do not override)
// PORTS
//  i_clk          in   1         clock
//  i_rstn         in   1         async active-low reset
//  i_nickel       in   1         coin strobe, 1 cycle per coin
//  i_dime         in   1         coin strobe
//  i_quarter      in   1         coin strobe
//  i_cancel       in   1         refund request, level or pulse
//  i_change_ack   in   1         dispenser accepted one nickel this cycle
//  o_vend         out  1         1-cycle pulse: release one product
//  o_change_req   out  1         request: dispense one nickel
//  o_coin_reject  out  1         1-cycle pulse: returned coin(s) this cycle
//  o_credit       out  CREDIT_W  current credit in units
//  o_busy         out  1         high in VEND/CHANGE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, credit=0, all outputs 0.
//  - States: IDLE (credit 0), COLLECT (0<credit<PRICE), VEND, CHANGE.
//  - Coins are accepted only in IDLE/COLLECT, and only when exactly one strobe is high.
//    The credit register adds the coin value on the next edge.
//  - Two or more strobes in the same cycle: no coin is accepted, credit is unchanged,
//    and o_coin_reject pulses on the next cycle.
//  - Any coin strobe in VEND/CHANGE: o_coin_reject pulses on the next cycle; credit is unchanged.
//  - IDLE/COLLECT -> VEND when the updated credit >= PRICE.
//    o_vend is high for exactly the one cycle spent in VEND (latency 1 after the coin edge).
//  - VEND: credit <= credit-PRICE. Next state is CHANGE if the remainder > 0, else IDLE.
//  - CHANGE: o_change_req = (credit != 0).
//    Each cycle with o_change_req & i_change_ack decrements credit by 1.
//    Leave CHANGE for IDLE on the edge where credit reaches 0; o_change_req drops the same cycle.
//    Worst-case remainder is PRICE-1+QUARTER_U-PRICE = QUARTER_U-1 nickels.
//  - i_cancel in COLLECT: enter CHANGE with the full credit (no vend).
//    i_cancel in IDLE/VEND/CHANGE: ignored.
//  - i_cancel and a valid coin in the same COLLECT cycle: the coin is added first,
//    then the price check runs. Vend wins if credit >= PRICE, else the refund covers the new credit.
//  - Credit saturation cannot occur (CREDIT_W covers the maximum); an assertion checks credit <= PRICE+QUARTER_U-1.
//  - o_credit, o_busy: registered, reflect current state.
// CONFIGURATION
//  VEND_STOCK_EN defined:
//   - adds input i_restock (1 bit) and output o_sold_out (1 bit).
//   - stock counter resets to STOCK_MAX, decrements on o_vend, and reloads to STOCK_MAX on i_restock in IDLE.
//   - stock==0: o_sold_out=1; coins in IDLE are rejected.
//   - stock==0 in COLLECT (stock ran out mid-transaction): credit is refunded via CHANGE.
//  VEND_STOCK_EN undefined: no stock logic or ports; stock is unlimited.
// STRUCTURE
//  - vend_pkg: state enum vend_state_e {IDLE,COLLECT,VEND,CHANGE}; coin-unit default constants;
//    function coin_value(n,d,q) returning units plus a valid flag.
//  - Sub-module vend_change_dispenser: owns the credit down-count and the req/ack handshake in CHANGE;
//    signals done to the FSM.
// TESTING
//  1 PRICE=4: dime, dime -> o_vend pulse 1 cycle after 2nd dime; no o_change_req; back to IDLE, credit 0.
//  2 quarter from IDLE -> o_vend, then 1 nickel via req/ack; ack held low 3 cycles stalls with o_change_req high.
//  3 nickel, dime, i_cancel -> no o_vend; 3 nickels returned; credit 3->0; IDLE.
//  4 dime+quarter in same cycle -> o_coin_reject pulse, credit unchanged; coin in CHANGE -> rejected.
//  5 reset asserted mid-CHANGE with credit 2 -> outputs 0 immediately; IDLE after release.
//  6 VEND_STOCK_EN, STOCK_MAX=1: vend once -> o_sold_out=1, next coin rejected;
//    i_restock in IDLE -> o_sold_out=0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM state encoding,
// default coin values in nickel units, and the coin-strobe decoder.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_e;

    localparam int NICKEL_UNITS  = 1;
    localparam int DIME_UNITS    = 2;
    localparam int QUARTER_UNITS = 5;

    typedef struct packed {
        logic       valid;
        logic       any;
        logic [7:0] units;
    } coin_t;

    // A coin is valid only when exactly one strobe is high; 'any' flags a strobe at all.
    function automatic coin_t coin_value(input logic n, input logic d, input logic q,
                                         input int nu = NICKEL_UNITS,
                                         input int du = DIME_UNITS,
                                         input int qu = QUARTER_UNITS);
        coin_t c;
        c.any   = n | d | q;
        c.valid = $onehot({n, d, q});
        c.units = '0;
        if (c.valid) begin
            if (n) c.units = 8'(nu);
            if (d) c.units = 8'(du);
            if (q) c.units = 8'(qu);
        end
        return c;
    endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Credit register for the vending controller: adds accepted coins, subtracts the price
// on vend, and pays change back one nickel per req/ack handshake while active.
module vend_change_dispenser #(
    parameter int PRICE     = 4,
    parameter int QUARTER_U = 5,
    parameter int CREDIT_W  = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                add,
    input  logic [CREDIT_W-1:0] add_units,
    input  logic                take_price,
    input  logic                active,
    input  logic                ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                req,
    output logic                done
);

    logic [CREDIT_W-1:0] credit_q;

    // Handshake: req stays high while credit remains; each cycle with req & ack moves one nickel.
    assign req    = active && (credit_q != '0);
    assign done   = active && ((credit_q == CREDIT_W'(1) && ack) || credit_q == '0);
    assign credit = credit_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit_q <= '0;
        end else if (add) begin
            credit_q <= credit_q + add_units;
        end else if (take_price) begin
            credit_q <= credit_q - CREDIT_W'(PRICE);
        end else if (req && ack) begin
            credit_q <= credit_q - CREDIT_W'(1);
        end
    end

    credit_max_a: assert property (@(posedge clk) disable iff (!rstn)
        credit_q <= CREDIT_W'(PRICE + QUARTER_U - 1));

endmodule

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: accumulates credit, vends at PRICE, pays change/refunds.
// Define VEND_STOCK_EN to add the inventory counter with i_restock / o_sold_out.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE     = 4,
    parameter int NICKEL_U  = NICKEL_UNITS,
    parameter int DIME_U    = DIME_UNITS,
    parameter int QUARTER_U = QUARTER_UNITS,
`ifdef VEND_STOCK_EN
    parameter int STOCK_MAX = 15,
`endif
    localparam int CREDIT_W = $clog2(PRICE + QUARTER_U + 1)
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_nickel,
    input  logic                i_dime,
    input  logic                i_quarter,
    input  logic                i_cancel,
    input  logic                i_change_ack,
`ifdef VEND_STOCK_EN
    input  logic                i_restock,
    output logic                o_sold_out,
`endif
    output logic                o_vend,
    output logic                o_change_req,
    output logic                o_coin_reject,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_busy,
    output logic [1:0]          o_state
);

    vend_state_e         state;
    vend_state_e         state_next;
    coin_t               coin;
    logic                collecting;
    logic                stock_empty;
    logic                accept;
    logic                reject_q;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_sum;
    logic                change_req;
    logic                change_done;

    assign coin       = coin_value(i_nickel, i_dime, i_quarter, NICKEL_U, DIME_U, QUARTER_U);
    assign collecting = (state == IDLE) || (state == COLLECT);
    // A sold-out machine refuses new transactions but still takes coins mid-transaction.
    assign accept     = collecting && coin.valid && !(stock_empty && state == IDLE);
    assign credit_sum = credit + (accept ? CREDIT_W'(coin.units) : '0);

    vend_change_dispenser #(
        .PRICE     (PRICE),
        .QUARTER_U (QUARTER_U),
        .CREDIT_W  (CREDIT_W)
    ) u_dispenser (
        .clk        (i_clk),
        .rstn       (i_rstn),
        .add        (accept),
        .add_units  (CREDIT_W'(coin.units)),
        .take_price (state == VEND),
        .active     (state == CHANGE),
        .ack        (i_change_ack),
        .credit     (credit),
        .req        (change_req),
        .done       (change_done)
    );

`ifdef VEND_STOCK_EN
    localparam int STOCK_W = $clog2(STOCK_MAX + 1);
    logic [STOCK_W-1:0] stock;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stock <= STOCK_W'(STOCK_MAX);
        end else if (state == VEND && stock != '0) begin
            stock <= stock - STOCK_W'(1);
        end else if (state == IDLE && i_restock) begin
            stock <= STOCK_W'(STOCK_MAX);
        end
    end

    assign stock_empty = (stock == '0);
    assign o_sold_out  = stock_empty;
`else
    assign stock_empty = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            reject_q <= 1'b0;
        end else begin
            state    <= state_next;
            reject_q <= coin.any && !accept;
        end
    end

    // The coin is counted before the price check, so a coin arriving with cancel can still vend.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, COLLECT: begin
                if (credit_sum >= CREDIT_W'(PRICE) && !stock_empty)
                    state_next = VEND;
                else if (state == COLLECT && (i_cancel || stock_empty))
                    state_next = CHANGE;
                else if (credit_sum != '0)
                    state_next = COLLECT;
                else
                    state_next = IDLE;
            end
            VEND:    state_next = (credit != CREDIT_W'(PRICE)) ? CHANGE : IDLE;
            CHANGE:  state_next = change_done ? IDLE : CHANGE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_vend        = (state == VEND);
        o_busy        = (state == VEND) || (state == CHANGE);
        o_change_req  = change_req;
        o_coin_reject = reject_q;
        o_credit      = credit;
        o_state       = state;
    end

endmodule
